apb_i2c_fifo: RTL and testbench
===============================

Name: apb_i2c_fifo

Overview:
Synchronous single-clock FIFO between the APB slave interface and the I2C core. One instance buffers TX data: the APB write strobe pushes and the I2C core pops. A second instance buffers RX data: the I2C core pushes and the APB read strobe pops. The read side is first-word-fall-through, so an APB read at address 4 returns the head word in the same access cycle in which the pop strobe is asserted. The block supplies the empty/full status that drives the TX_EMPTY/RX_EMPTY interrupts, plus a sticky error that feeds ERROR.

Parameters:
DWIDTH, 32, data word width in bits.
AWIDTH, 4, address width; DEPTH = 2**AWIDTH entries (16).
AF_LEVEL, 14, occupancy at or above which almost_full asserts; legal range 1..DEPTH.

Ports:
PCLK  input  1  system clock, all logic on rising edge.
PRESETn  input  1  asynchronous active-low reset.
clear  input  1  synchronous flush strobe.
wr_en  input  1  push strobe, one word per cycle.
wr_data  input  DWIDTH  push data.
rd_en  input  1  pop strobe, one word per cycle.
rd_data  output  DWIDTH  head-of-queue word, combinational (FWFT).
empty  output  1  occupancy == 0.
full  output  1  occupancy == DEPTH.
almost_full  output  1  occupancy >= AF_LEVEL.
count  output  AWIDTH+1  current occupancy, 0..DEPTH.
overflow  output  1  sticky: a push was attempted while full and not popped.
underflow  output  1  sticky: a pop was attempted while empty.
error  output  1  overflow | underflow.

Behaviour:
- Reset (PRESETn low, asynchronous): wptr=0, rptr=0, count=0, overflow=0, underflow=0.
  - Resulting outputs: empty=1, full=0, almost_full=0, error=0, rd_data=0.
  - Storage array is not reset.
  - Reset asserted mid-operation discards all contents immediately, with no clock edge needed.
- Pointers are AWIDTH bits wide and wrap naturally from DEPTH-1 to 0. count is a separate AWIDTH+1-bit register; empty and full decode from count only.
- rd_data = mem[rptr] when count != 0, and 0 when empty. It is valid in the same cycle rd_en is sampled, with zero read latency.
- Push accepted when wr_en=1 and (count<DEPTH, or count==DEPTH with rd_en=1 and the pop accepted):
  - mem[wptr] <= wr_data; wptr <= wptr+1.
  - Data is visible on rd_data the cycle after the push edge if the FIFO was empty. There is no same-cycle bypass.
- Pop accepted when rd_en=1 and count!=0: rptr <= rptr+1.
- Count update on each edge: +1 for a push alone, -1 for a pop alone, unchanged for both or neither.
- Boundary cases:
  - Full, wr_en only: push dropped; pointers, count and memory unchanged; overflow <= 1.
  - Full, wr_en and rd_en together: both accepted; count stays DEPTH; no overflow.
  - Empty, rd_en only: pop ignored; underflow <= 1; rd_data stays 0.
  - Empty, wr_en and rd_en together: push accepted, pop rejected; count becomes 1; underflow <= 1.
- clear=1 on an edge: wptr, rptr, count, overflow and underflow all go to 0. clear overrides wr_en and rd_en in the same cycle, and any push in that cycle is discarded.
- Sticky flags are cleared only by reset or clear.
- Status outputs are registered-derived. Flags reflect state after the last edge and never depend combinationally on wr_en or rd_en.

Decomposition:
- Shared package apb_i2c_pkg:
  - APB address constants: ADDR_TX=0, ADDR_RX=4, ADDR_CFG=8, ADDR_TIMEOUT=12.
  - FIFO_DWIDTH=32 and FIFO_AWIDTH=4 defaults.
  - Config/timeout field width constant = 14.
- One sub-module, apb_i2c_fifo_mem: the DEPTH x DWIDTH register array.
  - One write port, clocked, no reset.
  - One asynchronous read port.
  - Pointer, count and flag logic stay in apb_i2c_fifo.

Test Plan:
- Reset, then push 0xA5A5_0001 -> next cycle empty=0, count=1, rd_data=0xA5A5_0001. Pop -> empty=1, rd_data=0.
- Push 16 words 0x10..0x1F -> full=1, almost_full asserted at count=14, count=16. A 17th push of 0xFF -> overflow=1, error=1, count=16. Pop 16 -> data 0x10..0x1F in order, with no 0xFF.
- Wrap-around: push 10, pop 10, then push 0x20..0x2F (16 words) -> full=1 and pops return 0x20..0x2F in order across the pointer wrap.
- While full, wr_en and rd_en in the same cycle -> count stays 16, head advances by one, overflow stays 0. While empty, wr_en and rd_en together -> count=1, underflow=1.
- With count=5 and overflow=1, assert clear together with wr_en -> count=0, empty=1, overflow=0, underflow=0, and the pushed word is absent.
- With count=7, assert PRESETn low between clock edges -> empty=1 and count=0 without any clock edge. After release, the first push of 0x55 reads back 0x55.

Source files
------------

// File: rtl/apb_i2c_pkg.sv
// Shared constants for the APB I2C controller: register map, FIFO defaults
// and the config/timeout field width.
package apb_i2c_pkg;

    // APB register byte offsets
    localparam logic [7:0] ADDR_TX      = 8'h00;
    localparam logic [7:0] ADDR_RX      = 8'h04;
    localparam logic [7:0] ADDR_CFG     = 8'h08;
    localparam logic [7:0] ADDR_TIMEOUT = 8'h0C;

    // FIFO geometry defaults
    localparam int FIFO_DWIDTH = 32;
    localparam int FIFO_AWIDTH = 4;

    // Width of the config and timeout register fields
    localparam int CFG_FIELD_WIDTH = 14;

endpackage : apb_i2c_pkg

// File: rtl/apb_i2c_fifo_if.sv
// Push/pop/status bundle between a FIFO and its producer/consumer.
// The master drives the strobes and the slave (the FIFO) drives data and status.
interface apb_i2c_fifo_if
    import apb_i2c_pkg::*;
#(
    parameter int DWIDTH = FIFO_DWIDTH,
    parameter int AWIDTH = FIFO_AWIDTH
);
    logic              clear;
    logic              wr_en;
    logic [DWIDTH-1:0] wr_data;
    logic              rd_en;
    logic [DWIDTH-1:0] rd_data;
    logic              empty;
    logic              full;
    logic              almost_full;
    logic [AWIDTH:0]   count;
    logic              overflow;
    logic              underflow;
    logic              error;

    modport master (
        output clear, wr_en, wr_data, rd_en,
        input  rd_data, empty, full, almost_full, count, overflow, underflow, error
    );

    modport slave (
        input  clear, wr_en, wr_data, rd_en,
        output rd_data, empty, full, almost_full, count, overflow, underflow, error
    );

endinterface : apb_i2c_fifo_if

// File: rtl/apb_i2c_fifo_mem.sv
// FIFO storage: DEPTH x DWIDTH register array with one clocked write port
// and one asynchronous read port. Contents are deliberately not reset.
module apb_i2c_fifo_mem
    import apb_i2c_pkg::*;
#(
    parameter int DWIDTH = FIFO_DWIDTH,
    parameter int AWIDTH = FIFO_AWIDTH
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AWIDTH-1:0] waddr,
    input  logic [DWIDTH-1:0] wdata,
    input  logic [AWIDTH-1:0] raddr,
    output logic [DWIDTH-1:0] rdata
);

    logic [DWIDTH-1:0] mem_r [2**AWIDTH];

    // Write the addressed entry on an accepted push
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule : apb_i2c_fifo_mem

// File: rtl/apb_i2c_fifo.sv
// Single-clock first-word-fall-through FIFO used for the TX and RX paths of
// the APB I2C controller. Owns pointers, occupancy and sticky error flags;
// the storage array lives in apb_i2c_fifo_mem.
module apb_i2c_fifo
    import apb_i2c_pkg::*;
#(
    parameter int DWIDTH   = FIFO_DWIDTH,
    parameter int AWIDTH   = FIFO_AWIDTH,
    parameter int AF_LEVEL = 14
) (
    input  logic                 PCLK,
    input  logic                 PRESETn,
    apb_i2c_fifo_if.slave        bus
);

    localparam logic [AWIDTH:0] DEPTH_C    = (AWIDTH+1)'(2**AWIDTH);
    localparam logic [AWIDTH:0] AF_LEVEL_C = (AWIDTH+1)'(AF_LEVEL);
    localparam logic [AWIDTH:0] ONE_C      = (AWIDTH+1)'(1);

    logic [AWIDTH-1:0] wptr_r;
    logic [AWIDTH-1:0] rptr_r;
    logic [AWIDTH:0]   count_r;
    logic              overflow_r;
    logic              underflow_r;

    logic              empty_s;
    logic              full_s;
    logic              pop_s;
    logic              push_s;
    logic              we_s;
    logic [AWIDTH:0]   count_nxt_s;
    logic [DWIDTH-1:0] mem_rdata_s;
    logic [DWIDTH-1:0] rd_data_s;

    // Accept decisions; a pop frees the slot that lets a push into a full FIFO
    always_comb begin
        empty_s = (count_r == {(AWIDTH+1){1'b0}});
        full_s  = (count_r == DEPTH_C);
        pop_s   = bus.rd_en & ~empty_s;
        push_s  = bus.wr_en & (~full_s | pop_s);
        // A push in a clear cycle is discarded, so never touch the array then
        we_s    = push_s & ~bus.clear;
    end

    // Next occupancy: simultaneous push and pop leaves it unchanged
    always_comb begin
        count_nxt_s = count_r;
        if (push_s && !pop_s) begin
            count_nxt_s = count_r + ONE_C;
        end else if (pop_s && !push_s) begin
            count_nxt_s = count_r - ONE_C;
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Pointer, occupancy and sticky flag state; clear flushes everything
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wptr_r      <= {AWIDTH{1'b0}};
            rptr_r      <= {AWIDTH{1'b0}};
            count_r     <= {(AWIDTH+1){1'b0}};
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else if (bus.clear) begin
            wptr_r      <= {AWIDTH{1'b0}};
            rptr_r      <= {AWIDTH{1'b0}};
            count_r     <= {(AWIDTH+1){1'b0}};
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (push_s) begin
                wptr_r <= wptr_r + {{(AWIDTH-1){1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rptr_r <= rptr_r + {{(AWIDTH-1){1'b0}}, 1'b1};
            end
            count_r <= count_nxt_s;
            if (bus.wr_en && !push_s) begin
                overflow_r <= 1'b1;
            end
            if (bus.rd_en && empty_s) begin
                underflow_r <= 1'b1;
            end
        end
    end

    apb_i2c_fifo_mem #(
        .DWIDTH (DWIDTH),
        .AWIDTH (AWIDTH)
    ) u_mem (
        .clk   (PCLK),
        .we    (we_s),
        .waddr (wptr_r),
        .wdata (bus.wr_data),
        .raddr (rptr_r),
        .rdata (mem_rdata_s)
    );

    // Head word falls through; an empty FIFO presents zero, not stale storage
    always_comb begin
        rd_data_s = {DWIDTH{1'b0}};
        if (empty_s) begin
            rd_data_s = {DWIDTH{1'b0}};
        end else begin
            rd_data_s = mem_rdata_s;
        end
    end

    assign bus.rd_data     = rd_data_s;
    assign bus.empty       = empty_s;
    assign bus.full        = full_s;
    assign bus.almost_full = (count_r >= AF_LEVEL_C);
    assign bus.count       = count_r;
    assign bus.overflow    = overflow_r;
    assign bus.underflow   = underflow_r;
    assign bus.error       = overflow_r | underflow_r;

endmodule : apb_i2c_fifo

// File: tb/tb_apb_i2c_fifo.sv
// Directed bench for apb_i2c_fifo. Expected read data is queued by the
// stimulus and consumed by a monitor on every pop strobe; status outputs are
// compared against hand-computed constants.
module tb_apb_i2c_fifo;

    logic PCLK;
    logic PRESETn;

    int n_checks;
    int n_pass;

    logic [31:0] exp_q [$];

    apb_i2c_fifo_if #(.DWIDTH(32), .AWIDTH(4)) bus ();

    apb_i2c_fifo #(
        .DWIDTH   (32),
        .AWIDTH   (4),
        .AF_LEVEL (14)
    ) dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .bus     (bus)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    // Overall time bound
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end, time %0t", $time);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: on each pop strobe, head data must equal the scoreboard head
    // (or zero when the scoreboard says the FIFO is empty)
    always @(negedge PCLK) begin
        if (PRESETn && bus.rd_en && !bus.clear) begin
            if (exp_q.size() != 0) begin
                chk("rd_data", bus.rd_data, exp_q.pop_front());
            end else begin
                chk("rd_data_empty", bus.rd_data, 32'h0);
            end
        end
    end

    // One clock of stimulus; inputs change 1 time unit after the rising edge
    task automatic step(input logic w, input logic [31:0] d, input logic r, input logic c);
        bus.wr_en   = w;
        bus.wr_data = d;
        bus.rd_en   = r;
        bus.clear   = c;
        @(posedge PCLK);
        #1;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        bus.clear = 1'b0;
    endtask

    task automatic push(input logic [31:0] d, input logic accept);
        step(1'b1, d, 1'b0, 1'b0);
        if (accept) exp_q.push_back(d);
    endtask

    task automatic pop();
        step(1'b0, 32'h0, 1'b1, 1'b0);
    endtask

    initial begin
        n_checks    = 0;
        n_pass      = 0;
        bus.clear   = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_data = 32'h0;
        bus.rd_en   = 1'b0;
        PRESETn     = 1'b0;
        #23;
        PRESETn = 1'b1;
        @(posedge PCLK);
        #1;

        // Reset state
        chk("rst_empty", {31'h0, bus.empty}, 32'h1);
        chk("rst_full", {31'h0, bus.full}, 32'h0);
        chk("rst_af", {31'h0, bus.almost_full}, 32'h0);
        chk("rst_error", {31'h0, bus.error}, 32'h0);
        chk("rst_count", {27'h0, bus.count}, 32'h0);
        chk("rst_rd_data", bus.rd_data, 32'h0);

        // Single word fall-through
        push(32'hA5A5_0001, 1'b1);
        chk("one_empty", {31'h0, bus.empty}, 32'h0);
        chk("one_count", {27'h0, bus.count}, 32'h1);
        chk("one_rd_data", bus.rd_data, 32'hA5A5_0001);
        pop();
        chk("one_pop_empty", {31'h0, bus.empty}, 32'h1);
        chk("one_pop_rd_data", bus.rd_data, 32'h0);

        // Fill, almost_full threshold, overflow
        for (int i = 0; i < 16; i++) begin
            push(32'h10 + i, 1'b1);
            if (i == 12) chk("af_at_13", {31'h0, bus.almost_full}, 32'h0);
            if (i == 13) chk("af_at_14", {31'h0, bus.almost_full}, 32'h1);
        end
        chk("fill_full", {31'h0, bus.full}, 32'h1);
        chk("fill_count", {27'h0, bus.count}, 32'd16);
        push(32'hFF, 1'b0);
        chk("ovf_flag", {31'h0, bus.overflow}, 32'h1);
        chk("ovf_error", {31'h0, bus.error}, 32'h1);
        chk("ovf_count", {27'h0, bus.count}, 32'd16);
        for (int i = 0; i < 16; i++) pop();
        chk("drain_empty", {31'h0, bus.empty}, 32'h1);
        chk("ovf_sticky", {31'h0, bus.overflow}, 32'h1);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        chk("clr_ovf", {31'h0, bus.overflow}, 32'h0);

        // Pointer wrap
        for (int i = 0; i < 10; i++) push(32'h30 + i, 1'b1);
        for (int i = 0; i < 10; i++) pop();
        for (int i = 0; i < 16; i++) push(32'h20 + i, 1'b1);
        chk("wrap_full", {31'h0, bus.full}, 32'h1);

        // Full with simultaneous push and pop
        step(1'b1, 32'h40, 1'b1, 1'b0);
        exp_q.push_back(32'h40);
        chk("fullrw_count", {27'h0, bus.count}, 32'd16);
        chk("fullrw_head", bus.rd_data, 32'h21);
        chk("fullrw_ovf", {31'h0, bus.overflow}, 32'h0);
        for (int i = 0; i < 16; i++) pop();

        // Empty with simultaneous push and pop
        step(1'b1, 32'h50, 1'b1, 1'b0);
        exp_q.push_back(32'h50);
        chk("emptyrw_count", {27'h0, bus.count}, 32'h1);
        chk("emptyrw_udf", {31'h0, bus.underflow}, 32'h1);
        chk("emptyrw_head", bus.rd_data, 32'h50);
        pop();

        // Clear with a concurrent push, count=5 and overflow set
        step(1'b0, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) push(32'h60 + i, 1'b1);
        push(32'hEE, 1'b0);
        for (int i = 0; i < 11; i++) pop();
        chk("preclr_count", {27'h0, bus.count}, 32'd5);
        chk("preclr_ovf", {31'h0, bus.overflow}, 32'h1);
        step(1'b1, 32'h77, 1'b0, 1'b1);
        exp_q.delete();
        chk("clr_count", {27'h0, bus.count}, 32'h0);
        chk("clr_empty", {31'h0, bus.empty}, 32'h1);
        chk("clr_ovf2", {31'h0, bus.overflow}, 32'h0);
        chk("clr_udf", {31'h0, bus.underflow}, 32'h0);
        chk("clr_rd_data", bus.rd_data, 32'h0);
        push(32'h78, 1'b1);
        pop();

        // Asynchronous reset between edges with count=7
        for (int i = 0; i < 7; i++) push(32'h90 + i, 1'b1);
        chk("prerst_count", {27'h0, bus.count}, 32'd7);
        #2;
        PRESETn = 1'b0;
        #1;
        exp_q.delete();
        chk("arst_empty", {31'h0, bus.empty}, 32'h1);
        chk("arst_count", {27'h0, bus.count}, 32'h0);
        #3;
        PRESETn = 1'b1;
        @(posedge PCLK);
        #1;
        push(32'h55, 1'b1);
        chk("post_rst_head", bus.rd_data, 32'h55);
        pop();

        chk("sb_drained", exp_q.size(), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_apb_i2c_fifo
